// File: rtl/sipo.sv
// Serial-in/parallel-out packer: gathers 32-bit words from a show-ahead FIFO into
// 512-bit beats of 16 words, with a flush path that emits a zero-padded partial beat.
module sipo (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_empty,
  output logic         rd_en,
  input  logic [31:0]  rd_data,
  input  logic         wr_full,
  output logic         wr_en,
  output logic [511:0] wr_data,
  output logic [4:0]   wr_count,
  input  logic         flush,
  output logic         flush_busy
);

  logic [15:0][31:0] r_buf;
  logic [3:0]        r_cnt;
  logic              r_beat_valid;
  logic              r_flush_pend;
  logic [4:0]        r_wr_count;

  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_last_lane;
  logic              w_flush_fire;
  logic              w_flush_drop;
  logic [15:0][31:0] w_buf_next;

  // A waiting flush or a stalled full beat blocks further pops.
  assign w_rd_en      = ~rd_empty & ~r_flush_pend & (~r_beat_valid | ~wr_full) & ~rst;
  assign w_wr_en      = r_beat_valid & ~wr_full & ~rst;
  assign w_last_lane  = (r_cnt == 4'd15);
  assign w_flush_fire = r_flush_pend & ~r_beat_valid & (r_cnt != 4'd0);
  assign w_flush_drop = r_flush_pend & ~r_beat_valid & (r_cnt == 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      localparam logic [3:0] LANE = 4'(gi);
      // Lanes at or above the fill point are cleared when a partial beat is flushed.
      assign w_buf_next[gi] = (w_rd_en && (r_cnt == LANE))      ? rd_data :
                              (w_flush_fire && (LANE >= r_cnt)) ? 32'd0   :
                                                                  r_buf[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf        <= '0;
      r_cnt        <= 4'd0;
      r_beat_valid <= 1'b0;
      r_flush_pend <= 1'b0;
      r_wr_count   <= 5'd0;
    end else begin
      r_buf <= w_buf_next;

      if (w_rd_en) begin
        r_cnt <= r_cnt + 4'd1;
      end else if (w_flush_fire) begin
        r_cnt <= 4'd0;
      end

      if (w_rd_en && w_last_lane) begin
        r_beat_valid <= 1'b1;
        r_wr_count   <= 5'd16;
      end else if (w_flush_fire) begin
        r_beat_valid <= 1'b1;
        r_wr_count   <= {1'b0, r_cnt};
      end else if (w_wr_en) begin
        r_beat_valid <= 1'b0;
      end

      if (r_flush_pend) begin
        if (w_flush_fire || w_flush_drop) begin
          r_flush_pend <= 1'b0;
        end
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  assign rd_en      = w_rd_en;
  assign wr_en      = w_wr_en;
  assign wr_data    = r_buf;
  assign wr_count   = r_wr_count;
  assign flush_busy = r_flush_pend;

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: vector table, directed multi-cycle sequences and a
// randomized throttled stream checked against a word-queue reference model.
module tb_sipo;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_empty;
  logic         rd_en;
  logic [31:0]  rd_data;
  logic         wr_full;
  logic         wr_en;
  logic [511:0] wr_data;
  logic [4:0]   wr_count;
  logic         flush;
  logic         flush_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sipo dut (
    .clk        (clk),
    .rst        (rst),
    .rd_empty   (rd_empty),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .wr_full    (wr_full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_count   (wr_count),
    .flush      (flush),
    .flush_busy (flush_busy)
  );

  typedef struct packed {
    logic        empty;
    logic        full;
    logic        fl;
    logic [31:0] data;
    logic        e_rd;
    logic        e_wr;
    logic        e_busy;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_empty = 1'b1; wr_full = 1'b0; flush = 1'b0; rd_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [511:0]      beats [$];
    logic [15:0][31:0] eb;
    logic [31:0]       exp_q [$];
    logic [31:0]       cur_word;
    int                wr_cyc [$];
    int                nbeats;
    int                cyc;
    int                pend;

    // Reset with live inputs: everything gated while rst=1.
    rst = 1'b1; rd_empty = 1'b0; wr_full = 1'b0; flush = 1'b1; rd_data = 32'h1234;
    tick();
    tick();
    #4;
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_flush_busy", flush_busy, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b0; flush = 1'b0; rd_empty = 1'b1;
    tick();

    // Per-cycle vectors: empty-flush, 5-word flush, flush coinciding with pop, flush behind stalled beat.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0};
    for (int k = 0; k < 5; k++)
      tbl[3+k] = '{1'b0, 1'b0, 1'b0, 32'hA0 + 32'(k), 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd5};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'hB0, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'hB1, 1'b1, 1'b0, 1'b0, 5'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'hB2, 1'b0, 1'b0, 1'b1, 5'd0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 32'hB2, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, 5'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 32'hB2, 1'b0, 1'b1, 1'b1, 5'd2};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 32'hB2, 1'b0, 1'b0, 1'b1, 5'd0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 32'hB2, 1'b1, 1'b0, 1'b0, 5'd0};

    for (int i = 0; i < 20; i++) begin
      rd_empty = tbl[i].empty; wr_full = tbl[i].full; flush = tbl[i].fl; rd_data = tbl[i].data;
      #4;
      check($sformatf("vec%0d_rd_en", i), rd_en, tbl[i].e_rd);
      check($sformatf("vec%0d_wr_en", i), wr_en, tbl[i].e_wr);
      check($sformatf("vec%0d_flush_busy", i), flush_busy, tbl[i].e_busy);
      if (tbl[i].e_wr && wr_en) begin
        check($sformatf("vec%0d_wr_count", i), wr_count, tbl[i].e_cnt);
        beats.push_back(wr_data);
      end
      tick();
    end
    flush = 1'b0;
    check("vec_flush_beats", beats.size(), 2);
    if (beats.size() == 2) begin
      eb = '0;
      for (int k = 0; k < 5; k++) eb[k] = 32'hA0 + 32'(k);
      check("vec_flush_beat5_data", beats[0], eb);
      eb = '0;
      eb[0] = 32'hB0; eb[1] = 32'hB1;
      check("vec_flush_beat2_data", beats[1], eb);
    end

    // 32-word stream: two full beats, 16 cycles apart.
    do_reset();
    beats.delete();
    wr_cyc.delete();
    for (int c = 0; c < 36; c++) begin
      rd_empty = (c >= 32); rd_data = 32'(c);
      #4;
      if (c < 32) check($sformatf("s32_rd_en_c%0d", c), rd_en, 1);
      if (wr_en) begin
        beats.push_back(wr_data);
        wr_cyc.push_back(c);
        check($sformatf("s32_wr_count_c%0d", c), wr_count, 16);
      end
      tick();
    end
    check("s32_nbeats", beats.size(), 2);
    if (beats.size() == 2) begin
      check("s32_first_wr_cycle", wr_cyc[0], 16);
      check("s32_wr_spacing", wr_cyc[1] - wr_cyc[0], 16);
      for (int k = 0; k < 16; k++) eb[k] = 32'(k);
      check("s32_beat0_data", beats[0], eb);
      for (int k = 0; k < 16; k++) eb[k] = 32'(16 + k);
      check("s32_beat1_data", beats[1], eb);
    end

    // Full beat held off by wr_full for 5 cycles.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      rd_empty = 1'b0; rd_data = 32'h100 + 32'(c);
      tick();
    end
    for (int k = 0; k < 16; k++) eb[k] = 32'h100 + 32'(k);
    wr_full = 1'b1; rd_data = 32'hDEAD;
    for (int c = 0; c < 5; c++) begin
      #4;
      check($sformatf("bp_wr_en_c%0d", c), wr_en, 0);
      check($sformatf("bp_rd_en_c%0d", c), rd_en, 0);
      check($sformatf("bp_wr_data_c%0d", c), wr_data, eb);
      tick();
    end
    wr_full = 1'b0; rd_data = 32'h200;
    #4;
    check("bp_release_wr_en", wr_en, 1);
    check("bp_release_rd_en", rd_en, 1);
    check("bp_release_count", wr_count, 16);
    check("bp_release_data", wr_data, eb);
    tick();
    rd_data = 32'h201;
    #4;
    check("bp_after_wr_en", wr_en, 0);
    check("bp_after_rd_en", rd_en, 1);
    tick();

    // Partial beat discarded by reset, then a clean 16-word beat.
    do_reset();
    nbeats = 0;
    for (int c = 0; c < 7; c++) begin
      rd_empty = 1'b0; rd_data = 32'h300 + 32'(c);
      #4;
      if (wr_en) nbeats++;
      tick();
    end
    rst = 1'b1;
    #4;
    check("rstmid_rd_en", rd_en, 0);
    check("rstmid_wr_en", wr_en, 0);
    tick();
    rst = 1'b0;
    beats.delete();
    for (int c = 0; c < 19; c++) begin
      rd_empty = (c >= 16); rd_data = 32'h400 + 32'(c);
      #4;
      if (c == 0) check("rstmid_first_pop", rd_en, 1);
      if (c == 0) check("rstmid_busy", flush_busy, 0);
      if (wr_en) begin
        beats.push_back(wr_data);
        check("rstmid_wr_count", wr_count, 16);
      end
      tick();
    end
    check("rstmid_fragment_writes", nbeats, 0);
    check("rstmid_nbeats", beats.size(), 1);
    if (beats.size() == 1) begin
      for (int k = 0; k < 16; k++) eb[k] = 32'h400 + 32'(k);
      check("rstmid_beat_data", beats[0], eb);
    end

    // Random throttling against a queue model: the buffer holds a full beat when 16 words are pending.
    do_reset();
    exp_q.delete();
    cur_word = $urandom;
    nbeats = 0;
    cyc = 0;
    while (nbeats < 1000 && cyc < 60000) begin
      rd_empty = ($urandom_range(0, 3) == 0);
      wr_full  = ($urandom_range(0, 3) == 0);
      rd_data  = cur_word;
      #4;
      pend = exp_q.size();
      check("rnd_rd_en", rd_en, !rd_empty && !(pend >= 16 && wr_full));
      check("rnd_wr_en", wr_en, (pend >= 16) && !wr_full);
      check("rnd_no_wr_when_full", wr_en & wr_full, 0);
      check("rnd_no_rd_when_empty", rd_en & rd_empty, 0);
      if (wr_en && pend >= 16) begin
        for (int k = 0; k < 16; k++) eb[k] = exp_q[k];
        check($sformatf("rnd_beat%0d_data", nbeats), wr_data, eb);
        check("rnd_wr_count", wr_count, 16);
        for (int k = 0; k < 16; k++) void'(exp_q.pop_front());
        nbeats++;
      end
      if (rd_en) begin
        exp_q.push_back(cur_word);
        cur_word = $urandom;
      end
      cyc++;
      tick();
    end
    check("rnd_beats_done", nbeats, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo.md
SIPO -- requirements
Module: sipo

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32-bit in, 512-bit out, 16 words per beat).
REQ-002 clk  input  1  single clock for all logic; read-side and write-side FIFO ports both operate on it.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rd_empty  input  1  read-side FIFO empty; rd_data is show-ahead and valid whenever rd_empty=0.
REQ-005 rd_en  output  1  read-side pop; one 32-bit word consumed per cycle with rd_en=1.
REQ-006 rd_data  input  32  read-side word.
REQ-007 wr_full  input  1  write-side FIFO full.
REQ-008 wr_en  output  1  write-side push of one 512-bit beat.
REQ-009 wr_data  output  512  packed beat.
REQ-010 wr_count  output  5  number of valid words in the wr_data beat, 1..16; meaningful when wr_en=1.
REQ-011 flush  input  1  single-cycle request to emit the current partial beat.
REQ-012 flush_busy  output  1  flush request pending, not yet resolved.

Function
REQ-013 Internal state SHALL be: 512-bit accumulator buf; 4-bit word index cnt (0..15); beat_valid flag; flush_pend flag.
REQ-014 Word k of a beat (k=0 first popped) SHALL occupy wr_data[32k+31:32k].
REQ-015 wr_data SHALL equal buf; wr_en SHALL equal beat_valid & ~wr_full & ~rst.
REQ-016 rd_en SHALL equal ~rd_empty & ~flush_pend & (~beat_valid | ~wr_full) & ~rst.
REQ-017 On rd_en, rd_data SHALL be written to lane cnt of buf and cnt SHALL increment, wrapping 15->0.
REQ-018 When the popped word lands in lane 15, beat_valid SHALL be set and wr_count SHALL load 16 at the same edge; wr_en rises the following cycle (latency 1 cycle from 16th pop).
REQ-019 On wr_en without a same-cycle beat completion, beat_valid SHALL clear at that edge.
REQ-020 Simultaneous wr_en and rd_en SHALL be legal: the outgoing beat is captured by the FIFO at the edge where the new word enters lane 0; sustained throughput SHALL be one word per cycle (one beat per 16 cycles) when rd_empty=0 and wr_full=0.
REQ-021 While beat_valid=1 and wr_full=1, rd_en, buf, cnt and wr_count SHALL hold.
REQ-022 flush=1 SHALL set flush_pend; flush while flush_pend=1 SHALL have no additional effect; flush_busy SHALL equal flush_pend.
REQ-023 When flush_pend=1, beat_valid=0 and cnt>0: lanes cnt..15 of buf SHALL be zeroed, wr_count SHALL load cnt, beat_valid SHALL set, cnt SHALL reset to 0, flush_pend SHALL clear, all at one edge.
REQ-024 When flush_pend=1, beat_valid=0 and cnt=0, flush_pend SHALL clear with no beat emitted.
REQ-025 When flush_pend=1 and beat_valid=1, flush resolution SHALL wait until beat_valid=0; reads SHALL stay blocked meanwhile.
REQ-026 A flush arriving in the same cycle as a pop SHALL take effect after that pop (the popped word is included in the flushed beat).
REQ-027 wr_en SHALL never assert while wr_full=1; rd_en SHALL never assert while rd_empty=1.

Reset
REQ-028 With rst=1 at a clk edge: buf=0, cnt=0, beat_valid=0, flush_pend=0, wr_count=0.
REQ-029 While rst=1, rd_en=0, wr_en=0, flush_busy=0 after the first edge; a partial beat in flight SHALL be discarded without a write.
REQ-030 The first cycle after rst deasserts SHALL accept a pop if rd_empty=0.

Verification
REQ-031 Stream 32 words 0x00000000..0x0000001F, rd_empty=0, wr_full=0 -> rd_en high 32 consecutive cycles; two wr_en pulses, 16 cycles apart, first beat lane k = k, second lane k = 16+k, wr_count=16.
REQ-032 Complete beat with wr_full=1 held 5 cycles -> wr_en=0, rd_en=0, wr_data stable; on release wr_en for 1 cycle, then popping resumes.
REQ-033 Pop 5 words 0xA0..0xA4, rd_empty=1, pulse flush -> flush_busy 1 cycle; next cycle wr_en=1, wr_count=5, lanes 0..4 = 0xA0..0xA4, lanes 5..15 = 0.
REQ-034 Flush with cnt=0 and no pending beat -> flush_busy clears next cycle, no wr_en.
REQ-035 Pop 7 words, assert rst 1 cycle, then stream 16 words -> no wr_en for the 7-word fragment; single beat contains only the post-reset words, wr_count=16.
REQ-036 Random rd_empty/wr_full throttling, 1000 beats -> scoreboard matches every word in order, REQ-027 never violated.
